// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-to-UART drain stage: FSM state encoding and
// default timing constants used by the RTL and the bench.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  // 100 MHz system clock, 115200 baud
  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_RD_LATENCY   = 2;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between the FIFO controller (slave) and the UART
// drain stage (master), which owns the pop strobe.
interface fifo_uart_tx_if;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;

  modport master (input fifo_empty, input fifo_dout, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_dout, input fifo_rd_en);
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1, held at zero while clr is high.
// bit_next_end flags that the following cycle is the last one of a bit.
module uart_baud_counter
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end,
  output logic bit_next_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end      = (cnt_q == LAST);
  assign bit_next_end = (cnt_d == LAST);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one entry at a time and serialises each byte as an
// 8N1 UART frame. Every output is a flop loaded from next-state lookahead.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int RD_LATENCY   = DEF_RD_LATENCY
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           byte_done
);

  localparam int FW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [FW-1:0] FETCH_LAST = FW'(RD_LATENCY - 1);

  tx_state_e     state_q, state_d;
  logic [FW-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          rd_en_q, rd_en_d;
  logic          byte_done_q, byte_done_d;

  logic baud_clr;
  logic bit_end;
  logic bit_next_end;

  // Counter idles at zero outside the serial states so each bit starts clean
  assign baud_clr = (state_q == ST_IDLE) || (state_q == ST_FETCH);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk         (clk),
    .rst         (rst),
    .clr         (baud_clr),
    .bit_end     (bit_end),
    .bit_next_end(bit_next_end)
  );

  always_comb begin
    state_d     = state_q;
    fetch_cnt_d = '0;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    case (state_q)
      ST_IDLE: begin
        bit_idx_d = '0;
        if (!fifo.fifo_empty) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // The wait covers a head-byte RAM write that landed during IDLE
        if (fetch_cnt_q == FETCH_LAST) begin
          shift_d = fifo.fifo_dout;
          state_d = ST_START;
        end else begin
          fetch_cnt_d = fetch_cnt_q + FW'(1);
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output lookahead: decode the state the next cycle will be in
  always_comb begin
    rd_en_d     = (state_d == ST_FETCH) && (fetch_cnt_d == FETCH_LAST);
    busy_d      = (state_d != ST_IDLE);
    byte_done_d = (state_q == ST_STOP) && bit_next_end;
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fetch_cnt_q <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_cnt_q <= fetch_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign tx              = tx_q;
  assign busy            = busy_q;
  assign byte_done       = byte_done_q;
  assign fifo.fifo_rd_en = rd_en_q;

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Downstream drain stage for the 8-entry byte FIFO: watches the FIFO's `empty` flag, reads the head byte from the FIFO's block-RAM read port, and pops it with a single-cycle `rd_en` pulse. It then serialises the byte as an 8N1 UART frame on `tx`. It sits between the FIFO controller and the board's UART TX pin, so data written into the FIFO streams to the host at a fixed baud rate.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `RD_LATENCY`, default 2: cycles from a `read_index` change or RAM write until `fifo_dout` is valid; legal range ≥ 1.
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_dout` in 8: FIFO RAM read data (head byte).
- `fifo_rd_en` out 1: pop request; exactly one cycle high per byte.
- `tx` out 1: UART serial output; idle high.
- `busy` out 1: high in every state except IDLE.
- `byte_done` out 1: one-cycle pulse on the last cycle of each stop bit.

## Operation
- States:
  - IDLE
  - FETCH: RD_LATENCY cycles.
  - START: 1 bit time.
  - DATA: 8 bit times.
  - STOP: 1 bit time.
- IDLE → FETCH: on a cycle with `fifo_empty`=0.
- FETCH:
  - Counts RD_LATENCY cycles.
  - On its last cycle, latch `fifo_dout` into the 8-bit shift register and drive `fifo_rd_en`=1 for that cycle only.
  - → START.
- START: `tx`=0 for CLKS_PER_BIT cycles → DATA.
- DATA:
  - Shift out LSB first, `tx`=shift[0], for CLKS_PER_BIT cycles per bit.
  - A 3-bit bit index runs 0..7; after bit 7 → STOP.
- STOP: `tx`=1 for CLKS_PER_BIT cycles; `byte_done`=1 on the final cycle → IDLE.
- IDLE lasts at least one cycle, even if the FIFO is non-empty. The IDLE exit condition is evaluated on that cycle.
- Baud counter: width $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, clears on every state entry, and never wraps mid-bit.
- `fifo_rd_en` is never asserted outside the last FETCH cycle, so the block never pops an empty FIFO.
- `fifo_empty` cannot rise during FETCH, because this block is the sole reader.
- A FIFO write during IDLE or FETCH is handled by the RD_LATENCY wait. The head byte's RAM write settles before it is latched.
- Simultaneous FIFO write and this block's pop is legal. Occupancy is unchanged; the FIFO controller handles it.
- Reset values: state=IDLE, `tx`=1, `fifo_rd_en`=0, `busy`=0, `byte_done`=0, shift register=0, counters=0.
- Reset mid-frame: the next cycle `tx` is 1 and the state is IDLE. The partial frame is abandoned. A byte already popped is discarded, not re-sent. `rst` is normally shared with the FIFO.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Latency from `fifo_empty` falling (seen in IDLE) to the first `tx`=0 cycle: RD_LATENCY+1 cycles.
- `fifo_rd_en` is high on the cycle immediately before the first start-bit cycle.
- Frame length: 10·CLKS_PER_BIT cycles, from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back bytes: period is 10·CLKS_PER_BIT + 1 + RD_LATENCY cycles. The gap is IDLE plus FETCH, with `tx`=1 throughout.
- `busy` rises on the cycle after IDLE exits and falls on the first IDLE cycle.

## Structure
- Shared package `fifo_uart_pkg` holds:
  - the state encoding localparams (IDLE=0, FETCH=1, START=2, DATA=3, STOP=4; 3-bit);
  - the default CLKS_PER_BIT and RD_LATENCY constants, shared with the top level and the bench.
- One sub-module is natural: `uart_baud_counter`.
  - Parameter: CLKS_PER_BIT.
  - Inputs: `clr`.
  - Output: `bit_end` pulse, asserted when count==CLKS_PER_BIT-1.
- The FSM, shift register, FETCH counter and bit index live in `fifo_uart_tx`. Target 150–250 RTL lines total.

## Test plan
- Reset idle: hold `rst` 5 cycles with `fifo_empty`=1 → `tx`=1, `busy`=0, `fifo_rd_en`=0 throughout, and for 100 cycles after release.
- Single byte: CLKS_PER_BIT=4, RD_LATENCY=2; drop `fifo_empty` with `fifo_dout`=0xA5 →
  - `fifo_rd_en` one cycle, 2 cycles after IDLE exit;
  - `tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles;
  - `byte_done` one pulse at cycle 40 of the frame.
- Back-to-back: FIFO model preloaded with 0x00, 0xFF, 0x3C → three frames with exactly 3-cycle gaps, three `fifo_rd_en` pulses, then `busy`=0.
- Late arrival: write 0x81 while the block is in IDLE, with RAM latency 2 → transmitted byte is 0x81, not stale data.
- Reset mid-frame: assert `rst` during DATA bit 3 of 0x55 → `tx`=1 next cycle, state IDLE, no extra `fifo_rd_en`. After release, the next queued byte is sent intact.
- Full FIFO drain: 8 bytes 0x01..0x08 in a real `fifo_controller` →
  - 8 frames in order;
  - `fifo_rd_en` never high while `fifo_empty`=1;
  - FIFO occupancy ends at 0.
